// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives an 8-bit ALU from client requests or a sel sweep,
// and returns each captured outcome to the client over valid/ready.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int LAST_SEL      = 11,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [3:0]       req_sel,
    input  logic             sweep_start,
    input  logic [7:0]       sweep_a,
    input  logic [7:0]       sweep_b,
    output logic             sweep_busy,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [3:0]       rsp_sel,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [3:0] LAST = 4'(LAST_SEL);
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t           state_q;
    logic [SW-1:0]    cnt_q;
    logic             busy_q;
    logic [7:0]       alu_a_q, alu_b_q, rsp_result_q;
    logic [3:0]       alu_sel_q, rsp_sel_q;
    logic             rsp_valid_q, rsp_carry_q, rsp_zero_q, rsp_err_q;
    logic [CNT_W-1:0] op_count_q;
    logic             accept;

    // A same-cycle sweep_start wins, so the request must not see ready.
    assign req_ready = rst_n & (state_q == IDLE) & ~busy_q & ~sweep_start;
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_sel_q    <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        alu_a_q   <= sweep_a;
                        alu_b_q   <= sweep_b;
                        alu_sel_q <= '0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= DRIVE;
                    end else if (accept && req_sel <= LAST) begin
                        alu_a_q   <= req_a;
                        alu_b_q   <= req_b;
                        alu_sel_q <= req_sel;
                        cnt_q     <= '0;
                        state_q   <= DRIVE;
                    end else if (accept) begin
                        // Illegal code: answer directly, the ALU is never touched.
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_carry_q  <= 1'b0;
                        rsp_zero_q   <= 1'b0;
                        rsp_sel_q    <= req_sel;
                        state_q      <= RESP;
                    end
                end
                DRIVE: begin
                    if (cnt_q == SETTLE_END) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= 1'b0;
                        rsp_result_q <= alu_result;
                        rsp_carry_q  <= alu_carry;
                        rsp_zero_q   <= alu_zero;
                        rsp_sel_q    <= alu_sel_q;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + SW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        if (busy_q && rsp_sel_q < LAST) begin
                            alu_sel_q <= rsp_sel_q + 4'd1;
                            cnt_q     <= '0;
                            state_q   <= DRIVE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sweep_busy = busy_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_sel    = rsp_sel_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed stimulus with a queued scoreboard; a negedge
// monitor checks every response handshake and stall stability.
module tb_alu_op_sequencer;
    typedef logic [14:0] rsp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, sweep_start = 1'b0, rsp_ready = 1'b0;
    logic [7:0]  req_a = '0, req_b = '0, sweep_a = '0, sweep_b = '0;
    logic [3:0]  req_sel = '0;
    logic        req_ready, sweep_busy, rsp_valid, rsp_carry, rsp_zero, rsp_err;
    logic [7:0]  alu_a, alu_b, rsp_result, alu_result;
    logic [3:0]  alu_sel, rsp_sel;
    logic        alu_carry, alu_zero;
    logic [15:0] op_count;
    logic [8:0]  sum;

    int   tests = 0, fails = 0, n_rsp = 0;
    rsp_t q[$];
    rsp_t cur, held, e;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .sweep_start(sweep_start),
        .sweep_a(sweep_a), .sweep_b(sweep_b), .sweep_busy(sweep_busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_sel(rsp_sel), .rsp_err(rsp_err), .op_count(op_count)
    );

    // ALU stub: result = A+B+sel, carry out of bit 7.
    always_comb begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b} + {5'b0, alu_sel};
        alu_result = sum[7:0];
        alu_carry  = sum[8];
        alu_zero   = (sum[7:0] == 8'd0);
    end

    function automatic rsp_t mk(input logic [7:0] r, input logic c, z,
                                input logic [3:0] s, input logic err);
        return {r, c, z, s, err};
    endfunction

    function automatic logic [63:0] outs();
        return 64'({req_ready, sweep_busy, alu_a, alu_b, alu_sel, rsp_valid, rsp_result,
                    rsp_carry, rsp_zero, rsp_sel, rsp_err, op_count});
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cur = {rsp_result, rsp_carry, rsp_zero, rsp_sel, rsp_err};
        if (hold && rst_n) chk("stall_hold", 64'({rsp_valid, cur}), 64'({1'b1, held}));
        if (rst_n && rsp_valid && rsp_ready) begin
            chk("rsp_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rsp", 64'(cur), 64'(e));
            end
            n_rsp++;
        end
        hold = rst_n && rsp_valid && !rsp_ready;
        held = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, b, input logic [3:0] s);
        req_a = a; req_b = b; req_sel = s; req_valid = 1'b1;
        for (int i = 0; i < 200 && !req_ready; i++) tick();
        chk("accept_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (rsp_valid || q.size() > 0); i++) tick();
        chk("drain", 64'({rsp_valid, 8'(q.size())}), 64'd0);
    endtask

    task automatic op(input logic [7:0] a, b, input logic [3:0] s, input rsp_t x);
        logic [3:0] prev_sel;
        prev_sel = alu_sel;
        q.push_back(x);
        issue(a, b, s);
        if (x[0]) begin
            chk("err_immediate", 64'(rsp_valid), 64'd1);
            chk("err_alu_sel", 64'(alu_sel), 64'(prev_sel));
        end else begin
            chk("drive_gap", 64'(rsp_valid), 64'd0);
            tick();
            chk("latency", 64'(rsp_valid), 64'd1);
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("reset_out", outs(), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 64'(req_ready), 64'd1);

        op(8'd10, 8'd3, 4'd2, mk(8'd15, 1'b0, 1'b0, 4'd2, 1'b0));
        chk("op_count1", 64'(op_count), 64'd1);
        op(8'd200, 8'd100, 4'd0, mk(8'd44, 1'b1, 1'b0, 4'd0, 1'b0));
        op(8'd0, 8'd0, 4'd0, mk(8'd0, 1'b0, 1'b1, 4'd0, 1'b0));
        op(8'd5, 8'd6, 4'd13, mk(8'd0, 1'b0, 1'b0, 4'd13, 1'b1));
        op(8'd1, 8'd1, 4'd11, mk(8'd13, 1'b0, 1'b0, 4'd11, 1'b0));
        op(8'd9, 8'd9, 4'd12, mk(8'd0, 1'b0, 1'b0, 4'd12, 1'b1));
        chk("op_count6", 64'(op_count), 64'd6);
        chk("alu_sel_kept", 64'(alu_sel), 64'd11);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Sweep collides with a held request; the request must wait for the sweep.
        sweep_a = 8'd10; sweep_b = 8'd3; sweep_start = 1'b1;
        req_a = 8'd1; req_b = 8'd2; req_sel = 4'd3; req_valid = 1'b1;
        #1;
        chk("collide_ready", 64'(req_ready), 64'd0);
        for (int s = 0; s < 12; s++) q.push_back(mk(8'(13 + s), 1'b0, 1'b0, 4'(s), 1'b0));
        q.push_back(mk(8'd6, 1'b0, 1'b0, 4'd3, 1'b0));
        tick();
        sweep_start = 1'b0;
        chk("sweep_busy", 64'(sweep_busy), 64'd1);
        for (int i = 0; i < 500 && sweep_busy; i++) begin
            chk("busy_no_ready", 64'(req_ready), 64'd0);
            rsp_ready = (i % 3) != 1;
            tick();
        end
        chk("sweep_end", 64'({sweep_busy, req_ready, op_count}), 64'({1'b0, 1'b1, 16'd12}));
        chk("sweep_rsps", 64'(n_rsp), 64'd18);
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("post_collide_drive", 64'({rsp_valid, alu_sel}), 64'({1'b0, 4'd3}));
        wait_idle();
        chk("op_count13", 64'(op_count), 64'd13);

        issue(8'd7, 8'd7, 4'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_drive", outs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_drive_quiet", 64'({rsp_valid, op_count}), 64'd0);

        rsp_ready = 1'b0;
        issue(8'd7, 8'd7, 4'd1);
        tick();
        chk("resp_stalled", 64'(rsp_valid), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_resp", outs(), 64'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_resp_quiet", 64'({rsp_valid, op_count}), 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential initiator that drives the 8-bit `alu` (ports A, B, sel; returns result, carry, zero) and returns each outcome to a client over valid/ready.
- Two request sources: single client operations, and a hardware sweep that issues sel = 0..LAST_SEL on fixed operands.
- The sweep replaces the bench-only stepping loop with synthesizable control.
- Sits between a command source (CPU or host) and the `alu` instance.

Parameters:
- SETTLE_CYCLES, 1, number of cycles the ALU inputs are held stable before the outputs are captured (≥1).
- LAST_SEL, 11, highest legal sel code; higher codes are rejected.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; everything is updated on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req_valid  input  1  client operation request.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  8  operand A.
- req_b  input  8  operand B.
- req_sel  input  4  operation select.
- sweep_start  input  1  single-cycle pulse that starts a sweep.
- sweep_a  input  8  sweep operand A, sampled at start.
- sweep_b  input  8  sweep operand B, sampled at start.
- sweep_busy  output  1  sweep in progress.
- alu_a  output  8  registered drive to alu.A.
- alu_b  output  8  registered drive to alu.B.
- alu_sel  output  4  registered drive to alu.sel.
- alu_result  input  8  from alu.result.
- alu_carry  input  1  from alu.carry.
- alu_zero  input  1  from alu.zero.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  client accepts the response.
- rsp_result  output  8  captured result.
- rsp_carry  output  1  captured carry.
- rsp_zero  output  1  captured zero.
- rsp_sel  output  4  sel code of this response.
- rsp_err  output  1  sel was illegal; ALU was not driven.
- op_count  output  CNT_W  number of responses handed off; wraps.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - All outputs 0: req_ready, sweep_busy, alu_a/b/sel, rsp_valid, rsp_result/carry/zero/sel/err, op_count.
  - Reset mid-operation discards any pending operation or sweep without emitting a response.
- States: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready = 1 when not sweeping and sweep_start = 0; otherwise 0.
  - sweep_start=1 takes priority over req_valid in the same cycle: the request is not accepted.
  - On sweep start: latch sweep_a/sweep_b, set sweep_busy=1, issue sel=0.
  - On accept (req_valid & req_ready): latch req_a/b/sel.
  - Legal sel (≤ LAST_SEL): load alu_* and go to DRIVE, settle counter = 0.
  - Illegal sel: go directly to RESP with rsp_err=1, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_sel=req_sel; alu_* unchanged.
- DRIVE:
  - alu_* are held constant.
  - The counter increments each cycle.
  - On the edge where counter = SETTLE_CYCLES-1: capture alu_result/carry/zero into the rsp_* registers, set rsp_sel=alu_sel, rsp_err=0, rsp_valid=1, and go to RESP.
  - With SETTLE_CYCLES=1, rsp_valid rises one edge after the accept edge.
- RESP:
  - rsp_valid=1; all rsp_* are held stable until rsp_valid & rsp_ready.
  - On handshake:
    - op_count increments (wraps at 2^CNT_W).
    - rsp_valid drops on the same edge unless the next sweep step is captured later.
    - If sweeping and rsp_sel < LAST_SEL: alu_sel = rsp_sel+1 and go to DRIVE.
    - If sweeping and rsp_sel = LAST_SEL: sweep_busy=0 and go to IDLE.
    - Otherwise go to IDLE.
  - rsp_ready held low stalls indefinitely; no data is lost.
- sweep_start outside IDLE is ignored.
- req_valid is ignored while req_ready=0; the client must hold it (standard valid/ready).
- The block performs no arithmetic on ALU data; values pass bit-exact.

Test Plan:
- Bench ALU stub: result = (A+B+sel)[7:0], carry = bit 8, zero = (result==0).
- Single op: A=10, B=3, sel=2, rsp_ready=1 → rsp_valid one cycle after accept; rsp_result=15, carry=0, zero=0, rsp_sel=2; op_count=1.
- Carry/zero: A=200, B=100, sel=0 → result=44, carry=1. Then A=0, B=0, sel=0 → result=0, zero=1.
- Illegal sel: req_sel=13 → rsp_err=1, result=0, alu_sel unchanged, no DRIVE cycle; response next cycle.
- Sweep with stalls:
  - Stimulus: sweep_start with A=10, B=3; rsp_ready toggled 1-0-1.
  - Twelve responses with sel=0..11 and results 13..24.
  - Outputs stable while stalled; req_ready=0 throughout; sweep_busy falls after sel=11; op_count=12.
- Collision: sweep_start and req_valid in the same IDLE cycle → request not accepted; it is accepted only after the sweep ends.
- Reset mid-operation: rst_n=0 during DRIVE and again during RESP with rsp_ready=0 → all outputs 0 next cycle, no spurious response, op_count=0.
